// File: rtl/img_frame_sequencer_if.sv
// Pixel stream and raster-timing signals between the frame sequencer, its pixel
// source and the colour-space datapath.
interface img_frame_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        per_img_vsync;
  logic        per_img_href;
  logic [7:0]  per_img_red;
  logic [7:0]  per_img_green;
  logic [7:0]  per_img_blue;
  logic        post_img_vsync;

  // Sequencer side.
  modport master (
    input  s_valid,
    input  s_rgb,
    input  post_img_vsync,
    output s_ready,
    output per_img_vsync,
    output per_img_href,
    output per_img_red,
    output per_img_green,
    output per_img_blue
  );

  // Pixel source / datapath side.
  modport slave (
    output s_valid,
    output s_rgb,
    output post_img_vsync,
    input  s_ready,
    input  per_img_vsync,
    input  per_img_href,
    input  per_img_red,
    input  per_img_green,
    input  per_img_blue
  );
endinterface

// File: rtl/img_frame_sequencer.sv
// Runs one RGB frame per start pulse: pulls pixels from a valid/ready stream, generates
// vsync/href raster timing for the datapath and reports completion from post_img_vsync.
module img_frame_sequencer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned V_FRONT    = 5,
  parameter int unsigned H_BLANK    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  stall_seen,
  img_frame_sequencer_if.master pix
);

  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned TimMax = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
  localparam int unsigned TimW   = (TimMax > 1) ? $clog2(TimMax) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [TimW-1:0] VfLast  = TimW'(V_FRONT - 1);
  localparam logic [TimW-1:0] HbLast  = TimW'(H_BLANK - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVfront,
    StLine,
    StHblank,
    StDrain
  } state_e;

  state_e          state;
  logic [ColW-1:0] col_cnt;
  logic [RowW-1:0] row_cnt;
  logic [TimW-1:0] tim_cnt;
  logic            post_vsync_q;
  logic            vsync_q;
  logic            href_q;
  logic [7:0]      red_q;
  logic [7:0]      green_q;
  logic [7:0]      blue_q;

  logic            line_active;
  logic            accept;
  logic            vsync_fall;

  assign line_active = (state == StLine);
  assign accept      = pix.s_valid & line_active;
  assign vsync_fall  = post_vsync_q & ~pix.post_img_vsync;
  assign busy        = (state != StIdle);

  assign pix.s_ready       = line_active;
  assign pix.per_img_vsync = vsync_q;
  assign pix.per_img_href  = href_q;
  assign pix.per_img_red   = red_q;
  assign pix.per_img_green = green_q;
  assign pix.per_img_blue  = blue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      col_cnt      <= '0;
      row_cnt      <= '0;
      tim_cnt      <= '0;
      post_vsync_q <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      frame_done   <= 1'b0;
      stall_seen   <= 1'b0;
    end else begin
      post_vsync_q <= pix.post_img_vsync;
      href_q       <= accept;
      frame_done   <= 1'b0;

      if (accept) begin
        red_q   <= pix.s_rgb[23:16];
        green_q <= pix.s_rgb[15:8];
        blue_q  <= pix.s_rgb[7:0];
      end

      case (state)
        StIdle: begin
          if (frame_start) begin
            state      <= StVfront;
            vsync_q    <= 1'b1;
            col_cnt    <= '0;
            row_cnt    <= '0;
            tim_cnt    <= '0;
            stall_seen <= 1'b0;
          end
        end

        StVfront: begin
          if (tim_cnt == VfLast) begin
            tim_cnt <= '0;
            state   <= StLine;
          end else begin
            tim_cnt <= tim_cnt + TimW'(1);
          end
        end

        StLine: begin
          if (!pix.s_valid) begin
            stall_seen <= 1'b1;
          end else if (col_cnt == ColLast) begin
            if (row_cnt == RowLast) begin
              state <= StDrain;
            end else begin
              col_cnt <= '0;
              row_cnt <= row_cnt + RowW'(1);
              state   <= StHblank;
            end
          end else begin
            col_cnt <= col_cnt + ColW'(1);
          end
        end

        StHblank: begin
          if (tim_cnt == HbLast) begin
            tim_cnt <= '0;
            state   <= StLine;
          end else begin
            tim_cnt <= tim_cnt + TimW'(1);
          end
        end

        StDrain: begin
          // vsync drops one cycle after the last href; the done pulse is issued while
          // still in DRAIN so busy falls in the cycle after it.
          vsync_q <= 1'b0;
          if (frame_done) begin
            state <= StIdle;
          end else if (vsync_fall) begin
            frame_done <= 1'b1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

  col_in_range : assert property (@(posedge clk) disable iff (!rst_n) col_cnt <= ColLast);
  row_in_range : assert property (@(posedge clk) disable iff (!rst_n) row_cnt <= RowLast);
  done_to_idle : assert property (@(posedge clk) disable iff (!rst_n)
                                  frame_done |=> (state == StIdle));

endmodule
